// File: rtl/saturn_jump_decoder_pkg.sv
// -----------------------------------------------------------------------------
// saturn_jump_decoder_pkg
//   Shared types and constants for the Saturn jump/return front-end decoder:
//   FSM state encoding, jump-length codes (offset nibbles minus one), the
//   opcode nibbles that introduce jumps and returns, and a small decode record.
// -----------------------------------------------------------------------------
package saturn_jump_decoder_pkg;

  // Decoder states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,  // waiting for the first nibble of an instruction
    ST_OP0    = 3'd1,  // first nibble was 0, second nibble selects RTN variant
    ST_OP8    = 3'd2,  // first nibble was 8, second nibble selects long jump
    ST_OFFSET = 3'd3,  // consuming target offset nibbles with strobes held
    ST_SKIP   = 3'd4   // consuming the offset of a GOC/GONC that is not taken
  } jd_state_t;

  // Jump length codes: number of offset nibbles minus one.
  localparam logic [2:0] JL_NONE = 3'd0;
  localparam logic [2:0] JL_REL2 = 3'd1;
  localparam logic [2:0] JL_REL3 = 3'd2;
  localparam logic [2:0] JL_REL4 = 3'd3;
  localparam logic [2:0] JL_ABS5 = 3'd4;

  // Counter value of the last nibble consumed in ST_SKIP (two nibbles).
  localparam logic [2:0] SKIP_LAST = 3'd1;

  // First-nibble opcodes.
  localparam logic [3:0] OP_BLOCK0 = 4'h0;
  localparam logic [3:0] OP_GOC    = 4'h4;
  localparam logic [3:0] OP_GONC   = 4'h5;
  localparam logic [3:0] OP_GOTO   = 4'h6;
  localparam logic [3:0] OP_GOSUB  = 4'h7;
  localparam logic [3:0] OP_BLOCK8 = 4'h8;

  // Second nibble after 8.
  localparam logic [3:0] OP_GOLONG = 4'hC;
  localparam logic [3:0] OP_GOVLNG = 4'hD;
  localparam logic [3:0] OP_GOSUBL = 4'hE;
  localparam logic [3:0] OP_GOSBVL = 4'hF;

  // Second nibble after 0.
  localparam logic [3:0] OP_RTNSXM = 4'h0;
  localparam logic [3:0] OP_RTN    = 4'h1;
  localparam logic [3:0] OP_RTNSC  = 4'h2;
  localparam logic [3:0] OP_RTNCC  = 4'h3;

  // Result of classifying one nibble as a jump opcode.
  typedef struct packed {
    logic       hit;   // nibble starts a taken jump
    logic [2:0] len;   // jump length code
    logic       push;  // subroutine call
  } jump_dec_t;

  // True for the four return opcodes of the 0x block.
  function automatic logic is_rtn_op(input logic [3:0] nib);
    return (nib == OP_RTNSXM) || (nib == OP_RTN) ||
           (nib == OP_RTNSC)  || (nib == OP_RTNCC);
  endfunction

endpackage

// File: rtl/saturn_jump_decoder_if.sv
// -----------------------------------------------------------------------------
// saturn_jump_decoder_if
//   Groups the fetch-side inputs and the jump/RTN strobes of the decoder.
//   master : fetch/sequencer side (drives i_*, observes o_*)
//   slave  : the decoder (observes i_*, drives o_*)
//   Signals:
//     i_clk_en, i_phases[3:0], i_bus_busy, i_exec_unit_busy, i_instr_start,
//     i_nibble[3:0], i_carry, o_jump_instr, o_jump_length[2:0], o_push_pc,
//     o_block_0x, o_rtn_instr
// -----------------------------------------------------------------------------
interface saturn_jump_decoder_if;

  logic       i_clk_en;
  logic [3:0] i_phases;
  logic       i_bus_busy;
  logic       i_exec_unit_busy;
  logic       i_instr_start;
  logic [3:0] i_nibble;
  logic       i_carry;

  logic       o_jump_instr;
  logic [2:0] o_jump_length;
  logic       o_push_pc;
  logic       o_block_0x;
  logic       o_rtn_instr;

  modport master (
    output i_clk_en, i_phases, i_bus_busy, i_exec_unit_busy,
    output i_instr_start, i_nibble, i_carry,
    input  o_jump_instr, o_jump_length, o_push_pc, o_block_0x, o_rtn_instr
  );

  modport slave (
    input  i_clk_en, i_phases, i_bus_busy, i_exec_unit_busy,
    input  i_instr_start, i_nibble, i_carry,
    output o_jump_instr, o_jump_length, o_push_pc, o_block_0x, o_rtn_instr
  );

endinterface

// File: rtl/saturn_jump_decoder.sv
// -----------------------------------------------------------------------------
// saturn_jump_decoder
//   Front-end jump/return decoder. Watches the fetched nibble stream and
//   produces the strobes the PC/RSTK unit uses to build jump targets and pop
//   the return stack. Handles GOC/GONC/GOTO/GOSUB, GOLONG/GOVLNG/GOSUBL/GOSBVL
//   and RTNSXM/RTN/RTNSC/RTNCC. Jump strobes stay asserted while the offset
//   nibbles stream past so the PC/RSTK unit can assemble the target.
//
//   Ports:
//     i_clk      in  system clock
//     i_reset_n  in  asynchronous active-low reset
//     jd         slave modport of saturn_jump_decoder_if:
//                  i_clk_en/i_bus_busy/i_exec_unit_busy qualify every update,
//                  i_phases one-hot phase (nibble valid in phase 2),
//                  i_instr_start marks first nibble, i_nibble, i_carry,
//                  o_jump_instr, o_jump_length, o_push_pc, o_block_0x,
//                  o_rtn_instr
// -----------------------------------------------------------------------------
module saturn_jump_decoder
  import saturn_jump_decoder_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  saturn_jump_decoder_if.slave  jd
);

  // ---------------------------------------------------------------------------
  // Cycle qualification
  // ---------------------------------------------------------------------------
  logic adv;
  logic adv_ph2;
  logic adv_ph3;
  logic unused_phases;

  assign adv     = jd.i_clk_en & ~jd.i_bus_busy & ~jd.i_exec_unit_busy;
  assign adv_ph2 = adv & jd.i_phases[2];
  assign adv_ph3 = adv & jd.i_phases[3];

  // Phases 0 and 1 carry no work for this block.
  assign unused_phases = &{1'b0, jd.i_phases[1:0]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  jd_state_t  state_q,       state_d;
  logic [2:0] cnt_q,         cnt_d;
  logic       jump_instr_q,  jump_instr_d;
  logic [2:0] jump_length_q, jump_length_d;
  logic       push_pc_q,     push_pc_d;
  logic       block_0x_q,    block_0x_d;
  logic       rtn_instr_q,   rtn_instr_d;

  // ---------------------------------------------------------------------------
  // Opcode classifier
  //   short_dec : first nibble of an instruction (GOC/GONC/GOTO/GOSUB)
  //   short_skip: GOC/GONC whose condition fails; offset is consumed silently
  //   long_dec  : second nibble after 8 (GOLONG/GOVLNG/GOSUBL/GOSBVL)
  //   rtn_hit   : second nibble after 0 is one of the RTN variants
  // ---------------------------------------------------------------------------
  jump_dec_t short_dec;
  jump_dec_t long_dec;
  logic      short_skip;
  logic      rtn_hit;

  always_comb begin
    short_dec  = '0;
    short_skip = 1'b0;
    case (jd.i_nibble)
      OP_GOC: begin
        if (jd.i_carry) short_dec = '{hit: 1'b1, len: JL_REL2, push: 1'b0};
        else            short_skip = 1'b1;
      end
      OP_GONC: begin
        if (!jd.i_carry) short_dec = '{hit: 1'b1, len: JL_REL2, push: 1'b0};
        else             short_skip = 1'b1;
      end
      OP_GOTO:  short_dec = '{hit: 1'b1, len: JL_REL3, push: 1'b0};
      OP_GOSUB: short_dec = '{hit: 1'b1, len: JL_REL3, push: 1'b1};
      default:  short_dec = '0;
    endcase
  end

  always_comb begin
    long_dec = '0;
    case (jd.i_nibble)
      OP_GOLONG: long_dec = '{hit: 1'b1, len: JL_REL4, push: 1'b0};
      OP_GOVLNG: long_dec = '{hit: 1'b1, len: JL_ABS5, push: 1'b0};
      OP_GOSUBL: long_dec = '{hit: 1'b1, len: JL_REL4, push: 1'b1};
      OP_GOSBVL: long_dec = '{hit: 1'b1, len: JL_ABS5, push: 1'b1};
      default:   long_dec = '0;
    endcase
  end

  assign rtn_hit = is_rtn_op(jd.i_nibble);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    jump_instr_d  = jump_instr_q;
    jump_length_d = jump_length_q;
    push_pc_d     = push_pc_q;
    block_0x_d    = block_0x_q;
    rtn_instr_d   = rtn_instr_q;

    // RTN strobe lives for exactly one qualified phase-3 slot.
    if (adv_ph3 && rtn_instr_q) begin
      rtn_instr_d = 1'b0;
    end

    if (adv_ph2) begin
      case (state_q)
        ST_IDLE: begin
          // Only instruction-start nibbles are decoded; the rest belong to
          // instructions handled by other units.
          if (jd.i_instr_start) begin
            if (jd.i_nibble == OP_BLOCK0) begin
              state_d    = ST_OP0;
              block_0x_d = 1'b1;
            end else if (jd.i_nibble == OP_BLOCK8) begin
              state_d = ST_OP8;
            end else if (short_dec.hit) begin
              state_d       = ST_OFFSET;
              cnt_d         = 3'd0;
              jump_instr_d  = 1'b1;
              jump_length_d = short_dec.len;
              push_pc_d     = short_dec.push;
            end else if (short_skip) begin
              state_d = ST_SKIP;
              cnt_d   = 3'd0;
            end
          end
        end

        ST_OP0: begin
          block_0x_d = 1'b0;
          if (rtn_hit) begin
            rtn_instr_d = 1'b1;
          end
          state_d = ST_IDLE;
        end

        ST_OP8: begin
          if (long_dec.hit) begin
            state_d       = ST_OFFSET;
            cnt_d         = 3'd0;
            jump_instr_d  = 1'b1;
            jump_length_d = long_dec.len;
            push_pc_d     = long_dec.push;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_OFFSET: begin
          // The length code equals the index of the last offset nibble, so
          // the strobes drop on the edge that consumes that nibble.
          if (cnt_q == jump_length_q) begin
            state_d       = ST_IDLE;
            cnt_d         = 3'd0;
            jump_instr_d  = 1'b0;
            jump_length_d = JL_NONE;
            push_pc_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end

        ST_SKIP: begin
          if (cnt_q == SKIP_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end

        default: begin
          state_d       = ST_IDLE;
          cnt_d         = 3'd0;
          jump_instr_d  = 1'b0;
          jump_length_d = JL_NONE;
          push_pc_d     = 1'b0;
          block_0x_d    = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      jump_instr_q  <= 1'b0;
      jump_length_q <= JL_NONE;
      push_pc_q     <= 1'b0;
      block_0x_q    <= 1'b0;
      rtn_instr_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      jump_instr_q  <= jump_instr_d;
      jump_length_q <= jump_length_d;
      push_pc_q     <= push_pc_d;
      block_0x_q    <= block_0x_d;
      rtn_instr_q   <= rtn_instr_d;
    end
  end

  assign jd.o_jump_instr  = jump_instr_q;
  assign jd.o_jump_length = jump_length_q;
  assign jd.o_push_pc     = push_pc_q;
  assign jd.o_block_0x    = block_0x_q;
  assign jd.o_rtn_instr   = rtn_instr_q;

endmodule

// File: tb/tb_saturn_jump_decoder.sv
// -----------------------------------------------------------------------------
// tb_saturn_jump_decoder
//   Table of nibbles with the strobe values expected during the phase-3 slot
//   that follows each nibble, plus hand-written sequences for the RTN slot,
//   stalls and asynchronous reset.
//   Output pack used in comparisons: {jump_instr, jump_length[2:0], push_pc,
//   block_0x, rtn_instr}.
// -----------------------------------------------------------------------------
module tb_saturn_jump_decoder;

  logic clk;
  logic rst_n;

  saturn_jump_decoder_if jd ();

  saturn_jump_decoder dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .jd        (jd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output packs.
  localparam logic [6:0] E_IDLE   = 7'b0_000_0_0_0;
  localparam logic [6:0] E_REL2   = 7'b1_001_0_0_0;
  localparam logic [6:0] E_GOTO   = 7'b1_010_0_0_0;
  localparam logic [6:0] E_GOSUB  = 7'b1_010_1_0_0;
  localparam logic [6:0] E_GOLONG = 7'b1_011_0_0_0;
  localparam logic [6:0] E_GOSUBL = 7'b1_011_1_0_0;
  localparam logic [6:0] E_GOVLNG = 7'b1_100_0_0_0;
  localparam logic [6:0] E_GOSBVL = 7'b1_100_1_0_0;
  localparam logic [6:0] E_BLK    = 7'b0_000_0_1_0;
  localparam logic [6:0] E_RTN    = 7'b0_000_0_0_1;

  typedef struct {
    logic [3:0] nib;
    logic       st;
    logic       carry;
    logic [6:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_cmp;
  int   n_fail;

  function automatic logic [6:0] outs();
    return {jd.o_jump_instr, jd.o_jump_length, jd.o_push_pc,
            jd.o_block_0x, jd.o_rtn_instr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act[6:0], exp[6:0]);
    end
  endtask

  task automatic add(input logic [3:0] n, input logic st, input logic c, input logic [6:0] e);
    vec_t v;
    v.nib = n; v.st = st; v.carry = c; v.exp = e;
    vq.push_back(v);
  endtask

  // stall_kind: 0 bus_busy, 1 exec_unit_busy, 2 clock enable low
  task automatic set_stall(input int kind, input logic on);
    jd.i_bus_busy       = (kind == 0) ? on : 1'b0;
    jd.i_exec_unit_busy = (kind == 1) ? on : 1'b0;
    jd.i_clk_en         = (kind == 2) ? ~on : 1'b1;
  endtask

  // One nibble: closes the previous phase-3 slot, runs phases 0..2 with the
  // nibble presented in phase 2 (optionally stalled), and returns with the
  // outputs of the following phase-3 slot visible.
  task automatic nib(input logic [3:0] n, input logic st, input logic c,
                     input int stall_n, input int stall_kind, output logic blk_ph2);
    @(posedge clk); #1;
    jd.i_phases = 4'b0001;
    @(posedge clk); #1;
    jd.i_phases = 4'b0010;
    @(posedge clk); #1;
    jd.i_phases      = 4'b0100;
    jd.i_nibble      = n;
    jd.i_instr_start = st;
    jd.i_carry       = c;
    blk_ph2          = jd.o_block_0x;
    for (int k = 0; k < stall_n; k++) begin
      set_stall(stall_kind, 1'b1);
      @(posedge clk); #1;
    end
    set_stall(stall_kind, 1'b0);
    @(posedge clk); #1;
    jd.i_instr_start = 1'b0;
    jd.i_phases      = 4'b1000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic b;
    n_cmp  = 0;
    n_fail = 0;

    // GOTO 6,3,2,1
    add(4'h6, 1, 0, E_GOTO); add(4'h3, 0, 0, E_GOTO);
    add(4'h2, 0, 0, E_GOTO); add(4'h1, 0, 0, E_IDLE);
    // GOSBVL 8,F,5,4,3,2,1
    add(4'h8, 1, 0, E_IDLE); add(4'hF, 0, 0, E_GOSBVL);
    add(4'h5, 0, 0, E_GOSBVL); add(4'h4, 0, 0, E_GOSBVL);
    add(4'h3, 0, 0, E_GOSBVL); add(4'h2, 0, 0, E_GOSBVL);
    add(4'h1, 0, 0, E_IDLE);
    // RTN 0,1
    add(4'h0, 1, 0, E_BLK); add(4'h1, 0, 0, E_RTN);
    // GOC not taken, then GOTO decodes normally
    add(4'h4, 1, 0, E_IDLE); add(4'hA, 0, 0, E_IDLE); add(4'hB, 0, 0, E_IDLE);
    add(4'h6, 1, 0, E_GOTO); add(4'h3, 0, 0, E_GOTO);
    add(4'h2, 0, 0, E_GOTO); add(4'h1, 0, 0, E_IDLE);
    // GOC taken
    add(4'h4, 1, 1, E_REL2); add(4'hA, 0, 1, E_REL2); add(4'hB, 0, 1, E_IDLE);
    // GONC taken / not taken
    add(4'h5, 1, 0, E_REL2); add(4'h9, 0, 0, E_REL2); add(4'h9, 0, 0, E_IDLE);
    add(4'h5, 1, 1, E_IDLE); add(4'h1, 0, 1, E_IDLE); add(4'h2, 0, 1, E_IDLE);
    // GOSUB with a stray instr_start inside its offset
    add(4'h7, 1, 0, E_GOSUB); add(4'h6, 1, 0, E_GOSUB);
    add(4'h0, 0, 0, E_GOSUB); add(4'h0, 0, 0, E_IDLE);
    // non-start nibble ignored, 0x non-RTN, 8x non-jump
    add(4'h6, 0, 0, E_IDLE);
    add(4'h0, 1, 0, E_BLK); add(4'h4, 0, 0, E_IDLE);
    add(4'h8, 1, 0, E_IDLE); add(4'h0, 0, 0, E_IDLE); add(4'h6, 0, 0, E_IDLE);
    // GOLONG, GOVLNG, GOSUBL
    add(4'h8, 1, 0, E_IDLE); add(4'hC, 0, 0, E_GOLONG);
    add(4'h1, 0, 0, E_GOLONG); add(4'h2, 0, 0, E_GOLONG);
    add(4'h3, 0, 0, E_GOLONG); add(4'h4, 0, 0, E_IDLE);
    add(4'h8, 1, 0, E_IDLE); add(4'hD, 0, 0, E_GOVLNG);
    add(4'h1, 0, 0, E_GOVLNG); add(4'h2, 0, 0, E_GOVLNG);
    add(4'h3, 0, 0, E_GOVLNG); add(4'h4, 0, 0, E_GOVLNG);
    add(4'h5, 0, 0, E_IDLE);
    add(4'h8, 1, 0, E_IDLE); add(4'hE, 0, 0, E_GOSUBL);
    add(4'h1, 0, 0, E_GOSUBL); add(4'h2, 0, 0, E_GOSUBL);
    add(4'h3, 0, 0, E_GOSUBL); add(4'h4, 0, 0, E_IDLE);
    // RTNSC, RTNCC, RTNSXM
    add(4'h0, 1, 0, E_BLK); add(4'h2, 0, 0, E_RTN);
    add(4'h0, 1, 0, E_BLK); add(4'h3, 0, 0, E_RTN);
    add(4'h0, 1, 0, E_BLK); add(4'h0, 0, 0, E_RTN);

    // Reset
    rst_n               = 1'b0;
    jd.i_clk_en         = 1'b1;
    jd.i_bus_busy       = 1'b0;
    jd.i_exec_unit_busy = 1'b0;
    jd.i_phases         = 4'b1000;
    jd.i_instr_start    = 1'b0;
    jd.i_nibble         = 4'h0;
    jd.i_carry          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", {25'd0, outs()}, {25'd0, E_IDLE});
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_released", {25'd0, outs()}, {25'd0, E_IDLE});

    // Table
    foreach (vq[i]) begin
      nib(vq[i].nib, vq[i].st, vq[i].carry, 0, 0, b);
      $display("vec %0d nib=%h start=%b carry=%b outs=%b exp=%b",
               i, vq[i].nib, vq[i].st, vq[i].carry, outs(), vq[i].exp);
      chk($sformatf("vec%0d", i), {25'd0, outs()}, {25'd0, vq[i].exp});
    end

    // RTN: block_0x during second-nibble phase 2, rtn for one phase-3 slot,
    // held across a stalled phase-3 edge.
    nib(4'h0, 1, 0, 0, 0, b);
    nib(4'h1, 0, 0, 0, 0, b);
    $display("rtn seq blk_ph2=%b outs=%b", b, outs());
    chk("rtn_blk_ph2", {31'd0, b}, 32'd1);
    chk("rtn_ph3", {25'd0, outs()}, {25'd0, E_RTN});
    set_stall(0, 1'b1);
    @(posedge clk); #1;
    chk("rtn_stalled_ph3", {25'd0, outs()}, {25'd0, E_RTN});
    set_stall(0, 1'b0);
    @(posedge clk); #1;
    chk("rtn_cleared", {25'd0, outs()}, {25'd0, E_IDLE});

    // GOSUB with stalls mid-offset: exactly three offset nibbles still needed.
    nib(4'h7, 1, 0, 0, 0, b);
    chk("stall_gosub", {25'd0, outs()}, {25'd0, E_GOSUB});
    nib(4'hA, 0, 0, 3, 0, b);
    $display("stall bus outs=%b", outs());
    chk("stall_bus", {25'd0, outs()}, {25'd0, E_GOSUB});
    nib(4'hB, 0, 0, 2, 1, b);
    $display("stall exec outs=%b", outs());
    chk("stall_exec", {25'd0, outs()}, {25'd0, E_GOSUB});
    nib(4'hC, 0, 0, 2, 2, b);
    $display("stall clken outs=%b", outs());
    chk("stall_clken_last", {25'd0, outs()}, {25'd0, E_IDLE});

    // Asynchronous reset during GOLONG offset nibble 2.
    nib(4'h8, 1, 0, 0, 0, b);
    nib(4'hC, 0, 0, 0, 0, b);
    nib(4'h1, 0, 0, 0, 0, b);
    chk("areset_pre", {25'd0, outs()}, {25'd0, E_GOLONG});
    @(posedge clk); #1;
    jd.i_phases = 4'b0001;
    @(posedge clk); #1;
    jd.i_phases = 4'b0010;
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset outs=%b", outs());
    chk("areset_immediate", {25'd0, outs()}, {25'd0, E_IDLE});
    @(posedge clk); #1;
    rst_n       = 1'b1;
    jd.i_phases = 4'b1000;
    nib(4'h3, 0, 0, 0, 0, b);
    chk("areset_idle", {25'd0, outs()}, {25'd0, E_IDLE});
    nib(4'h6, 1, 0, 0, 0, b);
    chk("areset_goto", {25'd0, outs()}, {25'd0, E_GOTO});
    nib(4'h3, 0, 0, 0, 0, b);
    nib(4'h2, 0, 0, 0, 0, b);
    nib(4'h1, 0, 0, 0, 0, b);
    chk("areset_goto_end", {25'd0, outs()}, {25'd0, E_IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
